// File: rtl/alu_rr_scheduler_if.sv
// Request/response/ALU bundle for alu_rr_scheduler.
// master: scheduler side; slave: clients plus ALU side.
interface alu_rr_scheduler_if #(
    parameter int WIDTH = 4,
    parameter int N_ALU = 4,
    parameter int N_REQ = 4,
    parameter int SEL_W = 3
);
    localparam int DW   = N_ALU * WIDTH;
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*DW-1:0]    req_a;
    logic [N_REQ*DW-1:0]    req_b;
    logic [N_REQ*SEL_W-1:0] req_sel;

    logic [DW-1:0]          alu_a;
    logic [DW-1:0]          alu_b;
    logic [SEL_W-1:0]       alu_select;
    logic [DW-1:0]          alu_data_out;
    logic [N_ALU-1:0]       alu_carry_out;
    logic [N_ALU-1:0]       alu_a_greater;
    logic [N_ALU-1:0]       alu_a_equal;
    logic [N_ALU-1:0]       alu_a_less;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [DW-1:0]          rsp_data;
    logic [N_ALU-1:0]       rsp_carry;
    logic [3*N_ALU-1:0]     rsp_flags;

    modport master (
        input  req_valid, req_a, req_b, req_sel,
        input  alu_data_out, alu_carry_out,
        input  alu_a_greater, alu_a_equal, alu_a_less,
        input  rsp_ready,
        output req_ready, alu_a, alu_b, alu_select,
        output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_flags
    );

    modport slave (
        output req_valid, req_a, req_b, req_sel,
        output alu_data_out, alu_carry_out,
        output alu_a_greater, alu_a_equal, alu_a_less,
        output rsp_ready,
        input  req_ready, alu_a, alu_b, alu_select,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_flags
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one vector ALU among N_REQ clients.
// Ports: clk, rst (async, active-high), bus (alu_rr_scheduler_if.master).
// ALU_SCHED_STATS_EN adds op_count[15:0] (saturating) and busy outputs.
module alu_rr_scheduler #(
    parameter int WIDTH   = 4,
    parameter int N_ALU   = 4,
    parameter int N_REQ   = 4,
    parameter int SEL_W   = 3,
    parameter int ALU_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    alu_rr_scheduler_if.master bus
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic        busy
`endif
);
    localparam int DW    = N_ALU * WIDTH;
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(ALU_LAT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      a_q, a_d;
    logic [DW-1:0]      b_q, b_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [DW-1:0]      data_q, data_d;
    logic [N_ALU-1:0]   carry_q, carry_d;
    logic [3*N_ALU-1:0] flags_q, flags_d;
    logic [N_REQ-1:0]   ready;

    logic [ID_W-1:0]    grant;
    logic               grant_vld;
    int unsigned        idx;

    // First valid requester at or above the pointer, wrapping.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        id_d    = id_q;
        data_d  = data_q;
        carry_d = carry_q;
        flags_d = flags_q;
        ready   = '0;
        unique case (state_q)
            IDLE: begin
                // Reset is also gated here so no grant shows while held.
                if (grant_vld && !rst) begin
                    ready[grant] = 1'b1;
                    a_d     = bus.req_a[grant*DW +: DW];
                    b_d     = bus.req_b[grant*DW +: DW];
                    sel_d   = bus.req_sel[grant*SEL_W +: SEL_W];
                    id_d    = grant;
                    cnt_d   = LAT_C;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = bus.alu_data_out;
                    carry_d = bus.alu_carry_out;
                    flags_d = {bus.alu_a_greater,
                               bus.alu_a_equal,
                               bus.alu_a_less};
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            carry_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            flags_q <= flags_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_select = sel_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_flags  = flags_q;

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] cnt_ops_q, cnt_ops_d;

    always_comb begin
        cnt_ops_d = cnt_ops_q;
        if (state_q == RESP && bus.rsp_ready && cnt_ops_q != 16'hFFFF) begin
            cnt_ops_d = cnt_ops_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_ops_q <= '0;
        end else begin
            cnt_ops_q <= cnt_ops_d;
        end
    end

    assign op_count = cnt_ops_q;
    assign busy     = (state_q != IDLE);
`endif
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one vector ALU instance (N_ALU lanes of WIDTH bits, registered outputs) between N_REQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Drives the ALU operand and select inputs from registers, waits the ALU latency, then returns the captured result with the requester ID over a valid/ready response channel.
- Sits between the requester clients and the vector ALU; one transaction in flight at a time.

Parameters:
WIDTH, 4, bits per ALU lane
N_ALU, 4, number of ALU lanes
N_REQ, 4, number of requesters (>=2)
SEL_W, 3, width of ALU operation select
ALU_LAT, 1, ALU input-to-output latency in clocks (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  request valid per requester
req_ready  out  N_REQ  request accepted (one-hot or zero)
req_a  in  N_REQ*N_ALU*WIDTH  operand A per requester, requester i at slice i
req_b  in  N_REQ*N_ALU*WIDTH  operand B per requester
req_sel  in  N_REQ*SEL_W  operation select per requester
alu_a  out  N_ALU*WIDTH  operand A to ALU
alu_b  out  N_ALU*WIDTH  operand B to ALU
alu_select  out  SEL_W  select to ALU
alu_data_out  in  N_ALU*WIDTH  ALU result
alu_carry_out  in  N_ALU  ALU per-lane carry
alu_a_greater / alu_a_equal / alu_a_less  in  N_ALU each  ALU per-lane compare flags
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  $clog2(N_REQ)  index of the requester served
rsp_data  out  N_ALU*WIDTH  captured result
rsp_carry  out  N_ALU  captured carry
rsp_flags  out  3*N_ALU  captured {greater, equal, less}, each N_ALU wide

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr pointer=0, wait counter=0.
  - req_ready=0, rsp_valid=0.
  - rsp_id, rsp_data, rsp_carry, rsp_flags=0.
  - alu_a, alu_b, alu_select=0.
  - An in-flight transaction is dropped with no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching from the rr pointer upward modulo N_REQ.
  - req_ready[g]=1 combinationally in the same cycle; no other ready bit is set.
  - The handshake completes that cycle.
  - At that edge: alu_a, alu_b and alu_select load slice g; rsp_id<=g; counter<=ALU_LAT; go to WAIT.
  - With no valid request, stay in IDLE with req_ready=0.
- WAIT:
  - Lasts ALU_LAT+1 cycles; counter decrements each cycle.
  - Operand registers stay stable throughout.
  - On the last WAIT cycle (counter==0), capture alu_data_out, carry and flags into the rsp registers; go to RESP.
- RESP:
  - rsp_valid=1; rsp_* stay stable until rsp_ready=1.
  - On the handshake edge: rr pointer<=(g+1) mod N_REQ, go to IDLE.
  - A new grant occurs at the earliest in the next cycle.
- Latency:
  - Request accepted in cycle T; rsp_valid first high in cycle T+ALU_LAT+2.
  - Back-to-back throughput: one transaction per ALU_LAT+3 cycles when rsp_ready=1.
- req_ready is 0 in WAIT and RESP regardless of req_valid.
- The ALU operand and select outputs hold their last values in IDLE and RESP.
- Requesters must hold valid and payload until ready; the scheduler does not check this.
- rr pointer wrap: after serving N_REQ-1 the pointer returns to 0.
- A single active requester is served repeatedly.
- Select codes are passed through unchecked.
- Pointer and rsp_id widths use $clog2(N_REQ); for non-power-of-2 N_REQ the pointer wraps explicitly.

Optional Feature:
- ALU_SCHED_STATS_EN defined: adds output op_count (16 bits), reset 0.
  - Increments on each response handshake; saturates at 16'hFFFF.
  - Also adds output busy: 1 in WAIT and RESP, 0 in IDLE.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan (WIDTH=4, N_ALU=4, N_REQ=4, ALU_LAT=1; bench ALU model computes per-lane a+b when select=0):
1. Single request: req_valid=4'b0010, a=16'h1234, b=16'h1111, sel=0 at cycle 0 -> req_ready=4'b0010 in cycle 0; alu_a=16'h1234 in cycle 1; rsp_valid in cycle 3 with rsp_id=1, rsp_data=16'h2345.
2. Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0; responses spaced 4 cycles apart.
3. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable, req_ready=0 even with req_valid=4'b1111; first grant comes one cycle after the handshake.
4. Skip idle requesters: pointer=2, req_valid=4'b0001 -> grant 0 (wrap); next pointer=1.
5. Reset mid-operation: rst=1 in WAIT -> rsp_valid=0, alu_a=0, pointer=0; after release, req_valid=4'b1000 is granted with no stale response.
6. ALU_SCHED_STATS_EN: 3 completed transactions -> op_count=3; busy=1 exactly from the cycle after the grant through the response handshake cycle.
